// File: rtl/mux_a_if.sv
// mux_a_if: operand-A selector bus; master drives sources/select, slave returns the registered operand and flags.
// MUX_A_SEL_ERR_CNT_EN adds the err_cnt return signal.
interface mux_a_if #(
  parameter int WIDTH     = 11,
  parameter int ERR_CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] ULA_in;
  logic [WIDTH-1:0] EXT_in;
  logic [WIDTH-1:0] DATA_MEMORY_in;
  logic [1:0]       sel_A;
  logic [WIDTH-1:0] MA_out;
  logic             MA_valid;
  logic             sel_err;
`ifdef MUX_A_SEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master (output en, ULA_in, EXT_in, DATA_MEMORY_in, sel_A, input MA_out, MA_valid, sel_err, err_cnt);
  modport slave  (input en, ULA_in, EXT_in, DATA_MEMORY_in, sel_A, output MA_out, MA_valid, sel_err, err_cnt);
`else
  modport master (output en, ULA_in, EXT_in, DATA_MEMORY_in, sel_A, input MA_out, MA_valid, sel_err);
  modport slave  (input en, ULA_in, EXT_in, DATA_MEMORY_in, sel_A, output MA_out, MA_valid, sel_err);
`endif
endinterface

// File: rtl/mux_a.sv
// mux_a: registered 3-to-1 operand-A selector with illegal-select flag.
// MUX_A_SEL_ERR_CNT_EN adds a saturating illegal-select counter on bus.err_cnt.
module mux_a #(
  parameter int WIDTH     = 11,
  parameter int ERR_CNT_W = 8
) (
  input logic   clk,
  input logic   rst,
  mux_a_if.slave bus
);
  logic [WIDTH-1:0] w_next;
  logic             w_illegal;
  logic [WIDTH-1:0] r_ma;
  logic             r_valid;
  logic             r_err;
  // case default also catches X/Z selects in simulation, treating them as illegal
  always_comb begin
    w_next    = '0;
    w_illegal = 1'b0;
    case (bus.sel_A)
      2'b00:   w_next = bus.ULA_in;
      2'b01:   w_next = bus.EXT_in;
      2'b10:   w_next = bus.DATA_MEMORY_in;
      default: w_illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ma    <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (bus.en) r_ma <= w_next;
      r_valid <= bus.en & ~w_illegal;
      r_err   <= bus.en & w_illegal;
    end
  end
  assign bus.MA_out   = r_ma;
  assign bus.MA_valid = r_valid;
  assign bus.sel_err  = r_err;
`ifdef MUX_A_SEL_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err_cnt <= '0;
    else if (bus.en && w_illegal && r_err_cnt != '1) r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  end
  assign bus.err_cnt = r_err_cnt;
`endif
endmodule

// File: tb/tb_mux_a.sv
// tb_mux_a: table-driven check of mux_a plus reset, mid-cycle select and saturation sequences.
module tb_mux_a;
  localparam int W = 11;
  localparam int CW = 8;
  typedef struct {
    logic         en;
    logic [1:0]   sel;
    logic [W-1:0] ula, ext, dm;
    logic [W-1:0] exp_out;
    logic         exp_valid, exp_err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  vec_t tbl [14];
  mux_a_if #(.WIDTH(W), .ERR_CNT_W(CW)) bus ();
  mux_a #(.WIDTH(W), .ERR_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic en, input logic [1:0] sel, input logic [W-1:0] ula, ext, dm);
    bus.en = en; bus.sel_A = sel; bus.ULA_in = ula; bus.EXT_in = ext; bus.DATA_MEMORY_in = dm;
  endtask
  task automatic step();
    if (bus.en && bus.sel_A == 2'b11 && exp_cnt < 255) exp_cnt++;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string name);
`ifdef MUX_A_SEL_ERR_CNT_EN
    chk(name, 32'(bus.err_cnt), 32'(exp_cnt));
`endif
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'b00, 11'h782, 11'h071, 11'h000, 11'h782, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 11'h782, 11'h071, 11'h000, 11'h071, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 2'b10, 11'h782, 11'h071, 11'h000, 11'h000, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 11'h782, 11'h071, 11'h000, 11'h782, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 2'b11, 11'h782, 11'h071, 11'h000, 11'h000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 2'b00, 11'h782, 11'h071, 11'h000, 11'h782, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 2'b01, 11'h782, 11'h071, 11'h000, 11'h071, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'b00, 11'h123, 11'h071, 11'h000, 11'h071, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'b10, 11'h123, 11'h3c3, 11'h456, 11'h071, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 11'h7ff, 11'h3c3, 11'h456, 11'h071, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'b10, 11'h555, 11'h2aa, 11'h7ff, 11'h7ff, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 11'h555, 11'h2aa, 11'h7ff, 11'h555, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 2'b01, 11'h555, 11'h2aa, 11'h7ff, 11'h2aa, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'b11, 11'h555, 11'h2aa, 11'h7ff, 11'h000, 1'b0, 1'b1};
    drive(1'b1, 2'b01, 11'h782, 11'h071, 11'h000);
    #2;
    chk("reset MA_out", 32'(bus.MA_out), 32'h0);
    chk("reset MA_valid", 32'(bus.MA_valid), 32'h0);
    chk("reset sel_err", 32'(bus.sel_err), 32'h0);
    chk_cnt("reset err_cnt");
    @(posedge clk);
    #1;
    chk("held reset MA_out", 32'(bus.MA_out), 32'h0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].sel, tbl[i].ula, tbl[i].ext, tbl[i].dm);
      step();
      chk($sformatf("vec%0d MA_out", i), 32'(bus.MA_out), 32'(tbl[i].exp_out));
      chk($sformatf("vec%0d MA_valid", i), 32'(bus.MA_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d sel_err", i), 32'(bus.sel_err), 32'(tbl[i].exp_err));
      chk_cnt($sformatf("vec%0d err_cnt", i));
    end
    // only the select present at the edge counts
    drive(1'b1, 2'b10, 11'h782, 11'h071, 11'h000);
    #7;
    bus.sel_A = 2'b00;
    step();
    chk("late sel MA_out", 32'(bus.MA_out), 32'h782);
    chk("late sel MA_valid", 32'(bus.MA_valid), 32'h1);
    // async reset between edges, then first load after release
    #3;
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    chk("async rst MA_out", 32'(bus.MA_out), 32'h0);
    chk("async rst MA_valid", 32'(bus.MA_valid), 32'h0);
    chk("async rst sel_err", 32'(bus.sel_err), 32'h0);
    chk_cnt("async rst err_cnt");
    drive(1'b1, 2'b01, 11'h782, 11'h071, 11'h000);
    @(posedge clk);
    #2;
    chk("rst over edge MA_out", 32'(bus.MA_out), 32'h0);
    rst = 1'b0;
    step();
    chk("post rst MA_out", 32'(bus.MA_out), 32'h071);
    chk("post rst MA_valid", 32'(bus.MA_valid), 32'h1);
    drive(1'b1, 2'b11, 11'h782, 11'h071, 11'h000);
    for (int n = 0; n < 300; n++) begin
      step();
      chk("sat sel_err", 32'(bus.sel_err), 32'h1);
      chk("sat MA_valid", 32'(bus.MA_valid), 32'h0);
      if (n == 0 || n == 253 || n == 254 || n == 299) chk_cnt($sformatf("sat err_cnt n=%0d", n));
    end
    chk("sat MA_out", 32'(bus.MA_out), 32'h0);
`ifdef MUX_A_SEL_ERR_CNT_EN
    chk("sat err_cnt final", 32'(bus.err_cnt), 32'd255);
`endif
    drive(1'b0, 2'b11, 11'h782, 11'h071, 11'h000);
    step();
    chk("idle sel_err", 32'(bus.sel_err), 32'h0);
    chk_cnt("idle err_cnt");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_a.md
Name: mux_a

Overview:
- Registered 3-to-1 operand-A selector in the processor datapath.
- Picks between the ALU result (ULA_in), the sign/zero-extended immediate (EXT_in) and the data-memory read word (DATA_MEMORY_in) under control of sel_A.
- Drives the registered operand MA_out.
- Flags illegal select codes so the control unit can trap them.

Parameters:
- WIDTH, 11, bit width of every data input and of MA_out
- ERR_CNT_W, 8, width of the illegal-select counter (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- en  input  1  load enable; the output register updates only when en=1
- ULA_in  input  WIDTH  ALU result
- EXT_in  input  WIDTH  extended immediate
- DATA_MEMORY_in  input  WIDTH  data-memory read data
- sel_A  input  2  source select
- MA_out  output  WIDTH  registered selected operand
- MA_valid  output  1  high for the cycle after a legal load
- sel_err  output  1  high for the cycle after a load with sel_A=11
- err_cnt  output  ERR_CNT_W  illegal-select count (present only with the optional feature)

Behaviour:
- Select decode, purely combinational next value:
  - sel_A=00 -> ULA_in
  - sel_A=01 -> EXT_in
  - sel_A=10 -> DATA_MEMORY_in
  - sel_A=11 -> all zeros (illegal)
- On rising clk with en=1:
  - MA_out <= decoded value.
  - MA_valid <= (sel_A != 11).
  - sel_err <= (sel_A == 11).
- On rising clk with en=0:
  - MA_out holds its value.
  - MA_valid <= 0.
  - sel_err <= 0.
- Latency: exactly 1 clock from an en=1 edge to the new MA_out. No combinational path from any input to any output.
- Reset:
  - rst=1 forces MA_out=0, MA_valid=0, sel_err=0 (and err_cnt=0) immediately, independent of clk.
  - Reset asserted mid-operation discards any pending load.
  - The first load after rst deasserts happens on the first rising clk with en=1.
- sel_A changes between edges have no effect; only the value sampled at the edge matters.
- Data is passed through bit-exact: no arithmetic, no sign handling, no width change.
- X or Z on sel_A is treated as illegal in simulation (same result as 11).

Optional Feature:
- Macro: MUX_A_SEL_ERR_CNT_EN
- Defined:
  - err_cnt port exists.
  - err_cnt increments by 1 on every rising clk where en=1 and sel_A=11.
  - It saturates at 2^ERR_CNT_W-1 (no wrap).
  - Reset clears it to 0.
- Not defined:
  - err_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then en=1 with ULA_in=0x782, EXT_in=0x071, DATA_MEMORY_in=0x000: drive sel_A 00, 01, 10 on consecutive edges -> MA_out is 0x782, 0x071, 0x000 one cycle later each; MA_valid=1 each cycle; sel_err=0.
- Same inputs, sequence 00 -> 11 -> 00 -> MA_out 0x782, 0x000, 0x782; sel_err pulses 1 for exactly the middle cycle with MA_valid=0; err_cnt goes 0 -> 1 when the feature is enabled.
- Load 0x071 with sel_A=01, then en=0 while sel_A toggles and inputs change -> MA_out stays 0x071; MA_valid=0.
- Load 0x782, then assert rst between clock edges -> MA_out=0x000 and all flags 0 before the next edge; the first edge after release with en=1, sel_A=01 gives 0x071.
- With MUX_A_SEL_ERR_CNT_EN and ERR_CNT_W=8, apply 300 en=1 cycles with sel_A=11 -> err_cnt saturates at 255 and stays there; sel_err=1 each cycle.
